// File: rtl/uart_tx_sched.sv
// uart_tx_sched: byte FIFO feeding an 8N1 serial transmitter at a fixed
// clock divider. Reports occupancy, busy, sticky overflow and a drained
// level interrupt.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
//
// state   | meaning
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for CLK_DIV cycles
// S_DATA  | data bits, LSB first, CLK_DIV cycles each
// S_PARITY| even parity bit (only with UART_TX_PARITY_EN)
// S_STOP  | stop bit (high); chains straight into the next frame if queued
module uart_tx_sched #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_tx_valid,
    input  logic [DATA_WIDTH-1:0]         i_tx_data,
    input  logic                          i_clr_ovf,
    output logic                          o_tx_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_ovf,
    output logic                          o_txe_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_BIT    = IW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic                  full;
    logic                  push_ok;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // Full is taken from the registered count, so a same-edge pop never
    // makes room for a push.
    assign full    = (count_q == FULL_CNT);
    assign push_ok = i_tx_valid && !full;
    assign head    = mem_q[rd_ptr_q];

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_tx_data;
        end
    end

    // Occupancy update from accepted push and FSM pop.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sticky overflow; a new drop on the same edge as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (i_tx_valid && full) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO pointers, occupancy and overflow registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; tx_d is the line level for the state being entered,
    // so the registered line changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_RELOAD;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == '0) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        baud_d  = BAUD_RELOAD;
                        tx_d    = 1'b0;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Transmitter state register; reset forces the line high at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_tx       = tx_q;
    assign o_count    = count_q;
    assign o_ovf      = ovf_q;
    assign o_tx_ready = !full;
    assign o_busy     = (state_q != S_IDLE) || (count_q != '0);
    assign o_txe_irq  = (state_q == S_IDLE) && (count_q == '0);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched at CLK_DIV=4, FIFO_DEPTH=8.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_sched;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FL = FRAME_BITS * CLK_DIV;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       clr_ovf;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [3:0] count;
    logic       ovf;
    logic       txe;

    logic [8:0] st;
    assign st = {tx, busy, ready, txe, ovf, count};

    int checks   = 0;
    int failures = 0;

    logic line_q [4096];
    int   cyc = 0;

    logic [7:0] rx_q [$];
    int         frame_err;

    uart_tx_sched #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tx_valid(tx_valid),
        .i_tx_data (tx_data),
        .i_clr_ovf (clr_ovf),
        .o_tx_ready(ready),
        .o_tx      (tx),
        .o_busy    (busy),
        .o_count   (count),
        .o_ovf     (ovf),
        .o_txe_irq (txe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line recorder: sample index n holds o_tx just after rising edge n.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc < 4096) line_q[cyc] = tx;
            cyc++;
        end
    end

    // Expected line waveform for one frame, bit 0 = first cycle after the start edge.
    function automatic logic [43:0] expand(input logic [7:0] d);
        logic [10:0] f;
        logic [43:0] r;
`ifdef UART_TX_PARITY_EN
        f = {1'b1, ^d, d, 1'b0};
`else
        f = {2'b11, d, 1'b0};
`endif
        r = '0;
        for (int i = 0; i < FL; i++) r[i] = f[i / CLK_DIV];
        return r;
    endfunction

    // Reference receiver: mid-bit sampling of the recorded line.
    task automatic decode(input int from, input int upto);
        int i;
        logic [7:0] b;
        rx_q.delete();
        frame_err = 0;
        i = from;
        while (i + FL <= upto) begin
            if (line_q[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = line_q[i + CLK_DIV * (j + 1) + CLK_DIV / 2];
                if (line_q[i + CLK_DIV * (FRAME_BITS - 1) + CLK_DIV / 2] !== 1'b1) frame_err++;
                rx_q.push_back(b);
                i += FL;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (st !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0}) begin
            failures++; $display("FAIL reset_state: got %b expected %b", st, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0});
        end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (st !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0}) begin
            failures++; $display("FAIL reset_idle50: got %b expected %b", st, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0});
        end
    endtask

    task automatic test_single_frame();
        int base;
        logic [43:0] obs;
        base = cyc;
        tx_valid = 1'b1; tx_data = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (st !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            failures++; $display("FAIL single_after_push: got %b expected %b", st, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1});
        end
        repeat (FL) @(negedge clk);
        checks++;
        if (st !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            failures++; $display("FAIL single_stop_tail: got %b expected %b", st, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
        end
        @(negedge clk);
        checks++;
        if (st !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0}) begin
            failures++; $display("FAIL single_drained: got %b expected %b", st, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0});
        end
        obs = '0;
        for (int k = 0; k < FL; k++) obs[k] = line_q[base + 1 + k];
        checks++;
        if (obs !== expand(8'h55)) begin
            failures++; $display("FAIL single_0x55_line: got %h expected %h", obs, expand(8'h55));
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [87:0] obs;
        logic [87:0] exp2;
        base = cyc;
        tx_valid = 1'b1; tx_data = 8'hA3;
        @(negedge clk);
        tx_data = 8'h0F;
        checks++;
        if (count !== 4'd1) begin
            failures++; $display("FAIL b2b_count_e0: got %0d expected 1", count);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (count !== 4'd1) begin
            failures++; $display("FAIL b2b_count_e1: got %0d expected 1", count);
        end
        repeat (FL - 1) @(negedge clk);
        checks++;
        if (count !== 4'd1) begin
            failures++; $display("FAIL b2b_count_stop1: got %0d expected 1", count);
        end
        @(negedge clk);
        checks++;
        if ({tx, count} !== {1'b0, 4'd0}) begin
            failures++; $display("FAIL b2b_no_gap: got tx=%b count=%0d expected tx=0 count=0", tx, count);
        end
        repeat (FL) @(negedge clk);
        checks++;
        if ({busy, txe} !== 2'b01) begin
            failures++; $display("FAIL b2b_drained: got busy=%b txe=%b expected busy=0 txe=1", busy, txe);
        end
        obs = '0;
        for (int k = 0; k < 2 * FL; k++) obs[k] = line_q[base + 1 + k];
        exp2 = {44'b0, expand(8'hA3)} | ({44'b0, expand(8'h0F)} << FL);
        checks++;
        if (obs !== exp2) begin
            failures++; $display("FAIL b2b_line: got %h expected %h", obs, exp2);
        end
    endtask

    task automatic test_overflow();
        int base;
        int n;
        logic [7:0] got;
        base = cyc;
        for (int k = 0; k <= 10; k++) begin
            tx_valid = 1'b1; tx_data = 8'h10 + 8'(k);
            @(negedge clk);
            if (k == 8) begin
                checks++;
                if (st !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8}) begin
                    failures++; $display("FAIL ovf_just_full: got %b expected %b", st, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8});
                end
            end
        end
        tx_valid = 1'b0;
        checks++;
        if ({ready, ovf, count} !== {1'b0, 1'b1, 4'd8}) begin
            failures++; $display("FAIL ovf_set: got ready=%b ovf=%b count=%0d expected ready=0 ovf=1 count=8", ready, ovf, count);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
        tx_valid = 1'b1; tx_data = 8'hEE; clr_ovf = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if ({ovf, count} !== {1'b1, 4'd8}) begin
            failures++; $display("FAIL ovf_set_wins: got ovf=%b count=%0d expected ovf=1 count=8", ovf, count);
        end
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_clear2: got %b expected 0", ovf);
        end
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            failures++; $display("FAIL ovf_drain_timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
        repeat (20) @(negedge clk);
        decode(base, cyc);
        checks++;
        if (rx_q.size() !== 9 || frame_err !== 0) begin
            failures++; $display("FAIL ovf_frame_count: got %0d frames (%0d framing errs) expected 9 (0)", rx_q.size(), frame_err);
        end
        for (int k = 0; k < 9; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            checks++;
            if (got !== 8'h10 + 8'(k)) begin
                failures++; $display("FAIL ovf_byte%0d: got %h expected %h", k, got, 8'h10 + 8'(k));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] pat [2];
        int base2;
        int highs;
        pat[0] = 8'hFF; pat[1] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            tx_valid = 1'b1; tx_data = pat[p];
            @(negedge clk);
            tx_data = 8'h12;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (17) @(negedge clk);
            checks++;
            if ({tx, count} !== {pat[p][3], 4'd1}) begin
                failures++; $display("FAIL rstmid_pre%0d: got tx=%b count=%0d expected tx=%b count=1", p, tx, count, pat[p][3]);
            end
            rst_n = 1'b0;
            #1;
            checks++;
            if (st !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0}) begin
                failures++; $display("FAIL rstmid_async%0d: got %b expected %b", p, st, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0});
            end
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            base2 = cyc;
            repeat (100) @(negedge clk);
            highs = 0;
            for (int k = 0; k < 100; k++) if (line_q[base2 + k] === 1'b1) highs++;
            checks++;
            if (highs !== 100 || st !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0}) begin
                failures++; $display("FAIL rstmid_residual%0d: got %0d high samples state %b expected 100 and %b", p, highs, st, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0});
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d [2];
        logic       pexp [2];
        int base;
        d[0] = 8'h07; pexp[0] = 1'b1;
        d[1] = 8'h03; pexp[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            base = cyc;
            tx_valid = 1'b1; tx_data = d[p];
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (FL) @(negedge clk);
            checks++;
            if (txe !== 1'b0) begin
                failures++; $display("FAIL parity_len_short%0d: got txe=%b expected 0", p, txe);
            end
            @(negedge clk);
            checks++;
            if (txe !== 1'b1) begin
                failures++; $display("FAIL parity_len_end%0d: got txe=%b expected 1", p, txe);
            end
            checks++;
            if (line_q[base + 1 + CLK_DIV * 9 + CLK_DIV / 2] !== pexp[p]) begin
                failures++; $display("FAIL parity_bit%0d: got %b expected %b", p, line_q[base + 1 + CLK_DIV * 9 + CLK_DIV / 2], pexp[p]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
